// File: rtl/ref_window_loader_pkg.sv
// ref_window_loader_pkg: window geometry constants and bank-state encoding
package ref_window_loader_pkg;
    localparam int NUM_PIXEL = 8;
    localparam int TAPS = 8;
    localparam int PIX_W = 8;
    localparam int WIN = NUM_PIXEL + TAPS - 1;
    localparam int ROW_W = WIN * PIX_W;
    localparam int WIN_W = WIN * ROW_W;
    localparam int CNT_W = $clog2(WIN);
    typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_t;
endpackage

// File: rtl/ref_window_loader_bank.sv
// window_bank: row-addressable WIN x ROW_W window storage plus its fractional position
module window_bank
    import ref_window_loader_pkg::*;
(
    input  logic             clock,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_row,
    input  logic [ROW_W-1:0] wr_data,
    input  logic [3:0]       frac_in,
    output logic [WIN_W-1:0] data,
    output logic [3:0]       frac
);
    logic [WIN-1:0][ROW_W-1:0] rows;
    always_ff @(posedge clock) begin
        if (wr_en) rows[wr_row] <= wr_data;
        if (wr_en && wr_row == '0) frac <= frac_in;
    end
    assign data = rows;
endmodule

// File: rtl/ref_window_loader.sv
// ref_window_loader: ping-pong assembly of streamed reference rows into interpolator windows
module ref_window_loader
    import ref_window_loader_pkg::*;
(
    input  logic             clock,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_row,
    input  logic             in_last,
    input  logic [3:0]       in_frac,
    output logic             win_valid,
    input  logic             win_ack,
    output logic [WIN_W-1:0] win_data,
    output logic [3:0]       win_frac,
    output logic             err_framing
);
    bank_state_t state [2];
    bank_state_t state_nxt [2];
    logic wr_bank, rd_bank, wr_bank_nxt, rd_bank_nxt, err_nxt;
    logic [CNT_W-1:0] row_cnt, row_cnt_nxt;
    logic xfer, last_row, bad, done, ack;
    logic [WIN_W-1:0] bank_data [2];
    logic [3:0] bank_frac [2];
    assign in_ready = state[wr_bank] != FULL;
    assign win_valid = state[rd_bank] == FULL;
    assign xfer = in_valid && in_ready;
    assign last_row = row_cnt == CNT_W'(WIN - 1);
    assign bad = xfer && (in_last != last_row);
    assign done = xfer && in_last && last_row;
    assign ack = win_ack && win_valid;
    // outputs read as zero until a window is actually presented
    assign win_data = win_valid ? bank_data[rd_bank] : '0;
    assign win_frac = win_valid ? bank_frac[rd_bank] : '0;
    for (genvar b = 0; b < 2; b++) begin : g_bank
        window_bank u_bank (
            .clock  (clock),
            .wr_en  (xfer && wr_bank == (b == 1)),
            .wr_row (row_cnt),
            .wr_data(in_row),
            .frac_in(in_frac),
            .data   (bank_data[b]),
            .frac   (bank_frac[b])
        );
    end
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            row_cnt <= '0;
            err_framing <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_bank <= wr_bank_nxt;
            rd_bank <= rd_bank_nxt;
            row_cnt <= row_cnt_nxt;
            err_framing <= err_nxt;
        end
    end
    // a framing error drops the partial block but keeps the write pointer
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_nxt[b] = state[b];
            if (xfer && wr_bank == (b == 1)) state_nxt[b] = bad ? EMPTY : done ? FULL : FILLING;
            if (ack && rd_bank == (b == 1)) state_nxt[b] = EMPTY;
        end
        row_cnt_nxt = xfer ? ((bad || done) ? '0 : row_cnt + 1'b1) : row_cnt;
        wr_bank_nxt = wr_bank ^ done;
        rd_bank_nxt = rd_bank ^ ack;
        err_nxt = err_framing | bad;
    end
endmodule

// File: tb/tb_ref_window_loader.sv
// tb_ref_window_loader: directed scenario tests for the reference window loader
module tb_ref_window_loader;
    import ref_window_loader_pkg::*;
    logic clock = 1'b0;
    logic reset_L = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic win_ack = 1'b0;
    logic [ROW_W-1:0] in_row = '0;
    logic [3:0] in_frac = '0;
    logic in_ready, win_valid, err_framing;
    logic [WIN_W-1:0] win_data;
    logic [3:0] win_frac;
    int total = 0;
    int bad = 0;

    ref_window_loader dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .in_last    (in_last),
        .in_frac    (in_frac),
        .win_valid  (win_valid),
        .win_ack    (win_ack),
        .win_data   (win_data),
        .win_frac   (win_frac),
        .err_framing(err_framing)
    );

    always #5 clock = ~clock;

    task automatic send_block(input logic [7:0] base, input logic [3:0] frac, input int r0, input int r1,
                              input int last_idx, input bit ack_last, output int stalls);
        int wait_cyc;
        stalls = 0;
        for (int r = r0; r < r1; r++) begin
            wait_cyc = 0;
            in_valid = 1'b1;
            in_row = {WIN{8'(base + r)}};
            in_last = (r == last_idx);
            in_frac = (r == 0) ? frac : ~frac;
            win_ack = ack_last && (r == r1 - 1);
            while (!in_ready && wait_cyc < 20) begin
                stalls++;
                wait_cyc++;
                @(posedge clock);
                @(negedge clock);
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL beat_timeout: row %0d never accepted", r);
            end
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        win_ack = 1'b0;
    endtask

    task automatic ack_window();
        win_ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        win_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
        total++; if (err_framing !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_framing); end
        total++; if (win_data !== '0) begin bad++; $display("FAIL reset_win_data: got nonzero want 0"); end
        total++; if (win_frac !== 4'h0) begin bad++; $display("FAIL reset_win_frac: got %h want 0", win_frac); end
        reset_L = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_block();
        int s;
        send_block(8'h01, 4'h6, 0, 14, -1, 1'b0, s);
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", win_valid); end
        send_block(8'h01, 4'h6, 14, 15, 14, 1'b0, s);
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", win_valid); end
        total++; if (win_data[0+:8] !== 8'h01) begin bad++; $display("FAIL single_row0: got %h want 01", win_data[0+:8]); end
        total++; if (win_data[1680+:8] !== 8'h0F) begin bad++; $display("FAIL single_row14: got %h want 0f", win_data[1680+:8]); end
        total++; if (win_data[960+:8] !== 8'h09) begin bad++; $display("FAIL single_row8: got %h want 09", win_data[960+:8]); end
        total++; if (win_frac !== 4'h6) begin bad++; $display("FAIL single_frac: got %h want 6", win_frac); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        ack_window();
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL single_after_ack: got %b want 0", win_valid); end
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        send_block(8'h10, 4'h3, 0, 15, 14, 1'b0, s1);
        send_block(8'h20, 4'h9, 0, 15, 14, 1'b0, s2);
        total++; if (s1 + s2 !== 0) begin bad++; $display("FAIL b2b_stalls: got %0d want 0", s1 + s2); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
        total++; if (win_data[0+:8] !== 8'h10) begin bad++; $display("FAIL b2b_block1_row0: got %h want 10", win_data[0+:8]); end
        total++; if (win_data[1680+:8] !== 8'h1E) begin bad++; $display("FAIL b2b_block1_row14: got %h want 1e", win_data[1680+:8]); end
        total++; if (win_frac !== 4'h3) begin bad++; $display("FAIL b2b_block1_frac: got %h want 3", win_frac); end
        in_valid = 1'b1;
        in_row = {WIN{8'h55}};
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
        total++; if (win_data[0+:8] !== 8'h10) begin bad++; $display("FAIL b2b_stall_data: got %h want 10", win_data[0+:8]); end
        in_valid = 1'b0;
        ack_window();
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL b2b_block2_valid: got %b want 1", win_valid); end
        total++; if (win_data[0+:8] !== 8'h20) begin bad++; $display("FAIL b2b_block2_row0: got %h want 20", win_data[0+:8]); end
        total++; if (win_data[1799-:8] !== 8'h2E) begin bad++; $display("FAIL b2b_block2_row14: got %h want 2e", win_data[1799-:8]); end
        total++; if (win_frac !== 4'h9) begin bad++; $display("FAIL b2b_block2_frac: got %h want 9", win_frac); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_after_ack_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_simultaneous_ack();
        int s;
        send_block(8'h30, 4'hC, 0, 15, 14, 1'b1, s);
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL simul_valid: got %b want 1", win_valid); end
        total++; if (win_data[0+:8] !== 8'h30) begin bad++; $display("FAIL simul_row0: got %h want 30", win_data[0+:8]); end
        total++; if (win_data[1680+:8] !== 8'h3E) begin bad++; $display("FAIL simul_row14: got %h want 3e", win_data[1680+:8]); end
        total++; if (win_frac !== 4'hC) begin bad++; $display("FAIL simul_frac: got %h want c", win_frac); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL simul_ready: got %b want 1", in_ready); end
        ack_window();
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL simul_drain: got %b want 0", win_valid); end
    endtask

    task automatic test_early_last();
        int s;
        send_block(8'h40, 4'h5, 0, 10, 9, 1'b0, s);
        total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL early_err: got %b want 1", err_framing); end
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", win_valid); end
        send_block(8'h50, 4'h7, 0, 15, 14, 1'b0, s);
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL early_clean_valid: got %b want 1", win_valid); end
        total++; if (win_data[0+:8] !== 8'h50) begin bad++; $display("FAIL early_clean_row0: got %h want 50", win_data[0+:8]); end
        total++; if (win_data[1680+:8] !== 8'h5E) begin bad++; $display("FAIL early_clean_row14: got %h want 5e", win_data[1680+:8]); end
        total++; if (win_frac !== 4'h7) begin bad++; $display("FAIL early_clean_frac: got %h want 7", win_frac); end
        total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL early_err_sticky: got %b want 1", err_framing); end
        ack_window();
    endtask

    task automatic test_missing_last();
        int s;
        reset_L = 1'b0;
        @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        total++; if (err_framing !== 1'b0) begin bad++; $display("FAIL missing_pre_err: got %b want 0", err_framing); end
        send_block(8'h60, 4'h2, 0, 15, -1, 1'b0, s);
        total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL missing_err: got %b want 1", err_framing); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL missing_ready: got %b want 1", in_ready); end
        @(posedge clock);
        @(negedge clock);
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL missing_valid: got %b want 0", win_valid); end
        send_block(8'h70, 4'h4, 0, 15, 14, 1'b0, s);
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL missing_clean_valid: got %b want 1", win_valid); end
        total++; if (win_data[0+:8] !== 8'h70) begin bad++; $display("FAIL missing_clean_row0: got %h want 70", win_data[0+:8]); end
        total++; if (win_data[1680+:8] !== 8'h7E) begin bad++; $display("FAIL missing_clean_row14: got %h want 7e", win_data[1680+:8]); end
        total++; if (win_frac !== 4'h4) begin bad++; $display("FAIL missing_clean_frac: got %h want 4", win_frac); end
        ack_window();
    endtask

    task automatic test_reset_mid();
        int s;
        send_block(8'h80, 4'h1, 0, 15, 14, 1'b0, s);
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", win_valid); end
        send_block(8'h90, 4'h2, 0, 7, -1, 1'b0, s);
        reset_L = 1'b0;
        #1;
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", win_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_async_ready: got %b want 1", in_ready); end
        total++; if (err_framing !== 1'b0) begin bad++; $display("FAIL mid_async_err: got %b want 0", err_framing); end
        total++; if (win_data !== '0) begin bad++; $display("FAIL mid_async_data: got nonzero want 0"); end
        @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        send_block(8'hA0, 4'hA, 0, 15, 14, 1'b0, s);
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL mid_fresh_valid: got %b want 1", win_valid); end
        total++; if (win_data[0+:8] !== 8'hA0) begin bad++; $display("FAIL mid_fresh_row0: got %h want a0", win_data[0+:8]); end
        total++; if (win_data[1680+:8] !== 8'hAE) begin bad++; $display("FAIL mid_fresh_row14: got %h want ae", win_data[1680+:8]); end
        total++; if (win_frac !== 4'hA) begin bad++; $display("FAIL mid_fresh_frac: got %h want a", win_frac); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_simultaneous_ack();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
